// File: rtl/jk_pkg.sv
// jk_pkg: mode and JK code constants shared by the jk_reg_bank slice
package jk_pkg;
  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_t;
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;
endpackage

// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control/status bus of the register bank
import jk_pkg::*;
interface jk_reg_bank_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] changed;
  logic             sr_err;
  logic [CNT_W-1:0] chg_cnt;
  modport master (output en, mode, j, k, load, load_data, cnt_clr,
                  input q, q_bar, changed, sr_err, chg_cnt);
  modport slave  (input en, mode, j, k, load, load_data, cnt_clr,
                  output q, q_bar, changed, sr_err, chg_cnt);
endinterface

// File: rtl/jk_bit_next.sv
// jk_bit_next: next-state of one flip-flop bit for the selected mode
import jk_pkg::*;
module jk_bit_next (
  input  mode_t i_mode,
  input  logic  i_j,
  input  logic  i_k,
  input  logic  i_q,
  output logic  o_q_next,
  output logic  o_sr_illegal
);
  logic [1:0] w_jk;
  logic       w_jk_next;
  logic       w_sr_next;
  assign w_jk = {i_j, i_k};
  assign w_jk_next = w_jk == JK_HOLD  ? i_q :
                     w_jk == JK_RESET ? 1'b0 :
                     w_jk == JK_SET   ? 1'b1 : ~i_q;
  // S=R=1 holds rather than picking a winner
  assign w_sr_next = (i_j ^ i_k) ? i_j : i_q;
  assign o_q_next = i_mode == MODE_D  ? i_j :
                    i_mode == MODE_T  ? i_q ^ i_j :
                    i_mode == MODE_JK ? w_jk_next : w_sr_next;
  assign o_sr_illegal = (i_mode == MODE_SR) && i_j && i_k;
endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit JK/D/T/SR register bank with load, enable and change flags
// Optional saturating change counter enabled by macro JK_CHG_CNT_EN.
import jk_pkg::*;
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  jk_reg_bank_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic             r_sr_err;
  logic [WIDTH-1:0] w_bit_next;
  logic [WIDTH-1:0] w_illegal;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_diff;
  logic             w_sr_err;
  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      jk_bit_next u_bit (
        .i_mode      (bus.mode),
        .i_j         (bus.j[b]),
        .i_k         (bus.k[b]),
        .i_q         (r_q[b]),
        .o_q_next    (w_bit_next[b]),
        .o_sr_illegal(w_illegal[b])
      );
    end
  endgenerate
  assign w_q_next = bus.load ? bus.load_data : bus.en ? w_bit_next : r_q;
  assign w_diff   = w_q_next ^ r_q;
  assign w_sr_err = !bus.load && bus.en && |w_illegal;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RST_VAL;
      r_changed <= '0;
      r_sr_err  <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_diff;
      r_sr_err  <= w_sr_err;
    end
  end
`ifdef JK_CHG_CNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] r_cnt;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + PW'(w_diff[i]);
    w_sum = SW'(r_cnt) + SW'(w_pop);
  end
  // sum is one bit wider than either operand, so overflow is visible before saturating
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) r_cnt <= '0;
    else r_cnt <= w_sum > CNT_MAX ? '1 : w_sum[CNT_W-1:0];
  end
  assign bus.chg_cnt = r_cnt;
`else
  assign bus.chg_cnt = '0;
`endif
  assign bus.q       = r_q;
  assign bus.q_bar   = ~r_q;
  assign bus.changed = r_changed;
  assign bus.sr_err  = r_sr_err;
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed vectors for jk_reg_bank (RST_VAL=A5, CNT_W=4)
import jk_pkg::*;
module tb_jk_reg_bank;
  logic clk = 1'b0;
  logic rst;
  int   n_run = 0;
  int   n_fail = 0;
  jk_reg_bank_if #(.WIDTH(8), .CNT_W(4)) bus ();
  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef JK_CHG_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction
  task automatic drive(input logic ld, input logic [7:0] ld_d, input logic e,
                       input mode_t m, input logic [7:0] jv, input logic [7:0] kv);
    bus.load = ld;
    bus.load_data = ld_d;
    bus.en = e;
    bus.mode = m;
    bus.j = jv;
    bus.k = kv;
  endtask
  initial begin
    rst = 1'b1;
    bus.cnt_clr = 1'b0;
    drive(1'b1, 8'h11, 1'b1, MODE_T, 8'hFF, 8'h00);
    step();
    chk("rst_q", bus.q, 8'hA5);
    chk("rst_qbar", bus.q_bar, 8'h5A);
    chk("rst_changed", bus.changed, 8'h00);
    chk("rst_sr_err", bus.sr_err, 1'b0);
    chk("rst_cnt", bus.chg_cnt, 0);
    rst = 1'b0;
    drive(1'b1, 8'h00, 1'b0, MODE_JK, 8'h00, 8'h00);
    step();
    chk("load0_q", bus.q, 8'h00);
    chk("load0_changed", bus.changed, 8'hA5);
    drive(1'b0, 8'h00, 1'b1, MODE_JK, 8'hF0, 8'h0F);
    step();
    chk("jk_set_clr_q", bus.q, 8'hF0);
    drive(1'b0, 8'h00, 1'b1, MODE_JK, 8'hFF, 8'hFF);
    step();
    chk("jk_toggle_q", bus.q, 8'h0F);
    chk("jk_toggle_changed", bus.changed, 8'hFF);
    drive(1'b0, 8'h00, 1'b1, MODE_JK, 8'hFF, 8'h0F);
    step();
    chk("jk_mix_q", bus.q, 8'hF0);
    drive(1'b0, 8'h00, 1'b1, MODE_JK, 8'h00, 8'h00);
    step();
    chk("jk_hold_q", bus.q, 8'hF0);
    chk("jk_hold_changed", bus.changed, 8'h00);
    drive(1'b1, 8'h00, 1'b0, MODE_SR, 8'h00, 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b1, MODE_SR, 8'h03, 8'h01);
    step();
    chk("sr_q", bus.q, 8'h02);
    chk("sr_err_set", bus.sr_err, 1'b1);
    chk("sr_changed", bus.changed, 8'h02);
    bus.en = 1'b0;
    step();
    chk("en0_q", bus.q, 8'h02);
    chk("en0_sr_err", bus.sr_err, 1'b0);
    chk("en0_changed", bus.changed, 8'h00);
    drive(1'b0, 8'h00, 1'b1, MODE_SR, 8'h00, 8'h02);
    step();
    chk("sr_clr_q", bus.q, 8'h00);
    chk("sr_clr_err", bus.sr_err, 1'b0);
    drive(1'b0, 8'h00, 1'b1, MODE_D, 8'h5A, 8'hFF);
    step();
    chk("d_q", bus.q, 8'h5A);
    drive(1'b1, 8'h3C, 1'b1, MODE_T, 8'hFF, 8'h00);
    step();
    chk("load_wins_q", bus.q, 8'h3C);
    bus.load = 1'b0;
    step();
    chk("t_q", bus.q, 8'hC3);
    chk("t_changed", bus.changed, 8'hFF);
    bus.cnt_clr = 1'b1;
    step();
    chk("clr_q", bus.q, 8'h3C);
    chk("clr_cnt", bus.chg_cnt, 0);
    bus.cnt_clr = 1'b0;
    step();
    chk("cnt8", bus.chg_cnt, cexp(8));
    step();
    chk("cnt_sat_q", bus.q, 8'h3C);
    chk("cnt_sat", bus.chg_cnt, cexp(15));
    bus.cnt_clr = 1'b1;
    step();
    chk("clr_wins_q", bus.q, 8'hC3);
    chk("clr_wins_cnt", bus.chg_cnt, 0);
    bus.cnt_clr = 1'b0;
    step();
    chk("pre_rst_cnt", bus.chg_cnt, cexp(8));
    rst = 1'b1;
    step();
    chk("mid_rst_q", bus.q, 8'hA5);
    chk("mid_rst_changed", bus.changed, 8'h00);
    chk("mid_rst_cnt", bus.chg_cnt, 0);
    rst = 1'b0;
    step();
    chk("post_rst_q", bus.q, 8'h5A);
    chk("post_rst_cnt", bus.chg_cnt, cexp(8));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
